// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Shares the single register-file write port among three writers:
//            pipeline writeback (WB), the mult/div unit (MD) and the
//            debug/loader port (DBG). WB always wins. MD and DBG alternate
//            round-robin on cycles that WB leaves free. MD results land in a
//            1-entry hold buffer first. A per-register pending scoreboard
//            tracks MD destinations that are still in flight.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock            in   rising-edge system clock
//   ctrl_reset       in   asynchronous, active-high reset
//   wb_we/rd/data    in   writeback request (cannot be stalled)
//   md_issue/_rd     in   MD op started, marks destination pending
//   md_valid/rd/data in   MD result offer
//   md_ready         out  MD result accepted when md_valid is high
//   dbg_valid/rd/data in  debug write offer
//   dbg_ready        out  debug write accepted when dbg_valid is high
//   ctrl_writeEnable out  regfile write enable (registered)
//   ctrl_writeReg    out  regfile write address (registered)
//   data_writeReg    out  regfile write data (registered)
//   wr_src           out  0 none, 1 WB, 2 MD, 3 DBG (registered)
//   pending          out  per-register outstanding-MD scoreboard
// ============================================================================
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                       clock,
  input  logic                       ctrl_reset,
  input  logic                       wb_we,
  input  logic [ADDR_WIDTH-1:0]      wb_rd,
  input  logic [DATA_WIDTH-1:0]      wb_data,
  input  logic                       md_issue,
  input  logic [ADDR_WIDTH-1:0]      md_issue_rd,
  input  logic                       md_valid,
  output logic                       md_ready,
  input  logic [ADDR_WIDTH-1:0]      md_rd,
  input  logic [DATA_WIDTH-1:0]      md_data,
  input  logic                       dbg_valid,
  output logic                       dbg_ready,
  input  logic [ADDR_WIDTH-1:0]      dbg_rd,
  input  logic [DATA_WIDTH-1:0]      dbg_data,
  output logic                       ctrl_writeEnable,
  output logic [ADDR_WIDTH-1:0]      ctrl_writeReg,
  output logic [DATA_WIDTH-1:0]      data_writeReg,
  output logic [1:0]                 wr_src,
  output logic [(2**ADDR_WIDTH)-1:0] pending
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_WB   = 2'd1;
  localparam logic [1:0] SRC_MD   = 2'd2;
  localparam logic [1:0] SRC_DBG  = 2'd3;

  // Round-robin pointer: names the source that wins the next MD/DBG tie.
  typedef enum logic {
    RR_MD  = 1'b0,
    RR_DBG = 1'b1
  } rr_t;

  rr_t                   rr_ptr;
  logic                  hold_full;
  logic [ADDR_WIDTH-1:0] hold_rd;
  logic [DATA_WIDTH-1:0] hold_data;

  logic                  wb_active;
  logic                  grant_md;
  logic                  grant_dbg;
  logic                  md_accept;
  logic [NUM_REGS-1:0]   pending_next;

  // A WB write to r0 is a no-op and must not steal the port.
  assign wb_active = wb_we && (wb_rd != '0);

  // md_ready depends on state only. Because a drain clears hold_full at the
  // edge, a drained entry cannot be refilled until the following cycle.
  assign md_ready  = !hold_full;
  assign md_accept = md_valid && md_ready;

  // DBG is unbuffered, so it is ready exactly when it would win the port.
  assign dbg_ready = !wb_active && (!hold_full || (rr_ptr == RR_DBG));

  always_comb begin
    grant_md  = 1'b0;
    grant_dbg = 1'b0;
    if (!wb_active) begin
      if (hold_full && dbg_valid) begin
        if (rr_ptr == RR_MD) begin
          grant_md = 1'b1;
        end else begin
          grant_dbg = 1'b1;
        end
      end else if (hold_full) begin
        grant_md = 1'b1;
      end else if (dbg_valid) begin
        grant_dbg = 1'b1;
      end
    end
  end

  // Scoreboard update: the clear is applied first so that a same-cycle
  // re-issue of the draining index leaves the bit set.
  always_comb begin
    pending_next = pending;
    if (grant_md) begin
      pending_next[hold_rd] = 1'b0;
    end
    if (md_issue && (md_issue_rd != '0)) begin
      pending_next[md_issue_rd] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
      wr_src           <= SRC_NONE;
      pending          <= '0;
      hold_full        <= 1'b0;
      hold_rd          <= '0;
      hold_data        <= '0;
      rr_ptr           <= RR_MD;
    end else begin
      pending <= pending_next;

      // Output register. An r0 grant from MD/DBG consumes the request but
      // leaves the write disabled and the address/data untouched.
      if (wb_active) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= wb_rd;
        data_writeReg    <= wb_data;
        wr_src           <= SRC_WB;
      end else if (grant_md && (hold_rd != '0)) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= hold_rd;
        data_writeReg    <= hold_data;
        wr_src           <= SRC_MD;
      end else if (grant_dbg && (dbg_rd != '0)) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= dbg_rd;
        data_writeReg    <= dbg_data;
        wr_src           <= SRC_DBG;
      end else begin
        ctrl_writeEnable <= 1'b0;
        wr_src           <= SRC_NONE;
      end

      // Hold buffer: accept only happens while empty and drain only while
      // full, so the two never collide.
      if (grant_md) begin
        hold_full <= 1'b0;
      end else if (md_accept) begin
        hold_full <= 1'b1;
        hold_rd   <= md_rd;
        hold_data <= md_data;
      end

      if (grant_md) begin
        rr_ptr <= RR_DBG;
      end else if (grant_dbg) begin
        rr_ptr <= RR_MD;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Directed self-checking bench for regfile_write_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        md_issue = 1'b0;
  logic [4:0]  md_issue_rd = '0;
  logic        md_valid = 1'b0;
  logic        md_ready;
  logic [4:0]  md_rd = '0;
  logic [31:0] md_data = '0;
  logic        dbg_valid = 1'b0;
  logic        dbg_ready;
  logic [4:0]  dbg_rd = '0;
  logic [31:0] dbg_data = '0;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [1:0]  wr_src;
  logic [31:0] pending;

  int checks = 0;
  int failures = 0;

  regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_rd(dbg_rd), .dbg_data(dbg_data),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .wr_src(wr_src), .pending(pending)
  );

  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wb_we = 0; wb_rd = 0; wb_data = 0;
    md_issue = 0; md_issue_rd = 0;
    md_valid = 0; md_rd = 0; md_data = 0;
    dbg_valid = 0; dbg_rd = 0; dbg_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    tick();
    ctrl_reset = 1;
    #2;
    ctrl_reset = 0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ctrl_writeEnable !== 1'b0) begin failures++; $display("FAIL reset_we got=%0d exp=0", ctrl_writeEnable); end
    checks++; if (ctrl_writeReg !== 5'd0) begin failures++; $display("FAIL reset_reg got=%0d exp=0", ctrl_writeReg); end
    checks++; if (data_writeReg !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", data_writeReg); end
    checks++; if (wr_src !== 2'd0) begin failures++; $display("FAIL reset_src got=%0d exp=0", wr_src); end
    checks++; if (pending !== 32'd0) begin failures++; $display("FAIL reset_pending got=%h exp=0", pending); end
    checks++; if (md_ready !== 1'b1) begin failures++; $display("FAIL reset_md_ready got=%0d exp=1", md_ready); end
    checks++; if (dbg_ready !== 1'b1) begin failures++; $display("FAIL reset_dbg_ready got=%0d exp=1", dbg_ready); end
  endtask

  task automatic test_wb_write();
    do_reset();
    wb_we = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
    tick();
    wb_we = 0;
    checks++; if (ctrl_writeEnable !== 1'b1) begin failures++; $display("FAIL wb_we got=%0d exp=1", ctrl_writeEnable); end
    checks++; if (ctrl_writeReg !== 5'd5) begin failures++; $display("FAIL wb_reg got=%0d exp=5", ctrl_writeReg); end
    checks++; if (data_writeReg !== 32'hDEADBEEF) begin failures++; $display("FAIL wb_data got=%h exp=deadbeef", data_writeReg); end
    checks++; if (wr_src !== 2'd1) begin failures++; $display("FAIL wb_src got=%0d exp=1", wr_src); end
    tick();
    checks++; if (ctrl_writeEnable !== 1'b0) begin failures++; $display("FAIL wb_idle_we got=%0d exp=0", ctrl_writeEnable); end
    checks++; if (ctrl_writeReg !== 5'd5) begin failures++; $display("FAIL wb_idle_reg_hold got=%0d exp=5", ctrl_writeReg); end
  endtask

  task automatic test_md_behind_wb();
    do_reset();
    md_issue = 1; md_issue_rd = 7;
    tick();
    md_issue = 0;
    checks++; if (pending[7] !== 1'b1) begin failures++; $display("FAIL md_issue_pending got=%0d exp=1", pending[7]); end
    wb_we = 1; wb_rd = 1; wb_data = 32'hAAAA;
    md_valid = 1; md_rd = 7; md_data = 32'h12;
    #1;
    checks++; if (md_ready !== 1'b1) begin failures++; $display("FAIL md_ready_first got=%0d exp=1", md_ready); end
    tick();
    md_valid = 0;
    #1;
    checks++; if (md_ready !== 1'b0) begin failures++; $display("FAIL md_ready_held got=%0d exp=0", md_ready); end
    checks++; if (wr_src !== 2'd1) begin failures++; $display("FAIL md_wb_first_src got=%0d exp=1", wr_src); end
    tick();
    checks++; if (pending[7] !== 1'b1) begin failures++; $display("FAIL md_pending_wb2 got=%0d exp=1", pending[7]); end
    tick();
    wb_we = 0;
    #1;
    checks++; if (md_ready !== 1'b0) begin failures++; $display("FAIL md_ready_wb3 got=%0d exp=0", md_ready); end
    checks++; if (pending[7] !== 1'b1) begin failures++; $display("FAIL md_pending_predrain got=%0d exp=1", pending[7]); end
    tick();
    checks++; if (ctrl_writeEnable !== 1'b1) begin failures++; $display("FAIL md_commit_we got=%0d exp=1", ctrl_writeEnable); end
    checks++; if (ctrl_writeReg !== 5'd7) begin failures++; $display("FAIL md_commit_reg got=%0d exp=7", ctrl_writeReg); end
    checks++; if (data_writeReg !== 32'h12) begin failures++; $display("FAIL md_commit_data got=%h exp=12", data_writeReg); end
    checks++; if (wr_src !== 2'd2) begin failures++; $display("FAIL md_commit_src got=%0d exp=2", wr_src); end
    checks++; if (pending[7] !== 1'b0) begin failures++; $display("FAIL md_pending_clear got=%0d exp=0", pending[7]); end
    checks++; if (md_ready !== 1'b1) begin failures++; $display("FAIL md_ready_after_drain got=%0d exp=1", md_ready); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_src [4];
    logic [4:0] exp_reg [4];
    exp_src[0] = 2; exp_src[1] = 3; exp_src[2] = 2; exp_src[3] = 3;
    exp_reg[0] = 10; exp_reg[1] = 20; exp_reg[2] = 11; exp_reg[3] = 20;
    do_reset();
    md_valid = 1; md_rd = 10; md_data = 32'h100;
    tick();
    md_rd = 11; md_data = 32'h101;
    dbg_valid = 1; dbg_rd = 20; dbg_data = 32'h200;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (dbg_ready !== i[0]) begin failures++; $display("FAIL rr_dbg_ready[%0d] got=%0d exp=%0d", i, dbg_ready, i[0]); end
      tick();
      checks++; if (wr_src !== exp_src[i]) begin failures++; $display("FAIL rr_src[%0d] got=%0d exp=%0d", i, wr_src, exp_src[i]); end
      checks++; if (ctrl_writeReg !== exp_reg[i]) begin failures++; $display("FAIL rr_reg[%0d] got=%0d exp=%0d", i, ctrl_writeReg, exp_reg[i]); end
    end
    idle_inputs();
  endtask

  task automatic test_r0_writes();
    do_reset();
    dbg_valid = 1; dbg_rd = 0; dbg_data = 32'hFF;
    wb_we = 1; wb_rd = 0; wb_data = 32'h55;
    #1;
    checks++; if (dbg_ready !== 1'b1) begin failures++; $display("FAIL r0_dbg_ready got=%0d exp=1", dbg_ready); end
    tick();
    idle_inputs();
    checks++; if (ctrl_writeEnable !== 1'b0) begin failures++; $display("FAIL r0_dbg_we got=%0d exp=0", ctrl_writeEnable); end
    md_valid = 1; md_rd = 0; md_data = 32'h77;
    tick();
    md_valid = 0;
    #1;
    checks++; if (md_ready !== 1'b0) begin failures++; $display("FAIL r0_md_held got=%0d exp=0", md_ready); end
    tick();
    checks++; if (ctrl_writeEnable !== 1'b0) begin failures++; $display("FAIL r0_md_we got=%0d exp=0", ctrl_writeEnable); end
    checks++; if (md_ready !== 1'b1) begin failures++; $display("FAIL r0_md_consumed got=%0d exp=1", md_ready); end
  endtask

  task automatic test_pending_set_wins();
    do_reset();
    md_issue = 1; md_issue_rd = 9;
    tick();
    md_issue = 0;
    md_valid = 1; md_rd = 9; md_data = 32'h99;
    tick();
    md_valid = 0;
    md_issue = 1; md_issue_rd = 9;
    tick();
    md_issue = 0;
    checks++; if (wr_src !== 2'd2) begin failures++; $display("FAIL sb_drain_src got=%0d exp=2", wr_src); end
    checks++; if (ctrl_writeReg !== 5'd9) begin failures++; $display("FAIL sb_drain_reg got=%0d exp=9", ctrl_writeReg); end
    checks++; if (pending !== 32'h0000_0200) begin failures++; $display("FAIL sb_set_wins got=%h exp=00000200", pending); end
    do_reset();
    md_issue = 1; md_issue_rd = 0;
    tick();
    md_issue = 0;
    checks++; if (pending !== 32'd0) begin failures++; $display("FAIL sb_r0_issue got=%h exp=0", pending); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    md_issue = 1; md_issue_rd = 3;
    tick();
    md_issue = 0;
    wb_we = 1; wb_rd = 4; wb_data = 32'h44;
    md_valid = 1; md_rd = 3; md_data = 32'h33;
    tick();
    idle_inputs();
    #1;
    checks++; if (ctrl_writeEnable !== 1'b1) begin failures++; $display("FAIL rst_pre_we got=%0d exp=1", ctrl_writeEnable); end
    checks++; if (md_ready !== 1'b0) begin failures++; $display("FAIL rst_pre_md_ready got=%0d exp=0", md_ready); end
    checks++; if (pending !== 32'h0000_0008) begin failures++; $display("FAIL rst_pre_pending got=%h exp=00000008", pending); end
    ctrl_reset = 1;
    #1;
    checks++; if (ctrl_writeEnable !== 1'b0) begin failures++; $display("FAIL rst_async_we got=%0d exp=0", ctrl_writeEnable); end
    checks++; if (ctrl_writeReg !== 5'd0) begin failures++; $display("FAIL rst_async_reg got=%0d exp=0", ctrl_writeReg); end
    checks++; if (data_writeReg !== 32'd0) begin failures++; $display("FAIL rst_async_data got=%h exp=0", data_writeReg); end
    checks++; if (wr_src !== 2'd0) begin failures++; $display("FAIL rst_async_src got=%0d exp=0", wr_src); end
    checks++; if (pending !== 32'd0) begin failures++; $display("FAIL rst_async_pending got=%h exp=0", pending); end
    checks++; if (md_ready !== 1'b1) begin failures++; $display("FAIL rst_async_md_ready got=%0d exp=1", md_ready); end
    #1;
    ctrl_reset = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ctrl_writeEnable !== 1'b0) begin failures++; $display("FAIL rst_dropped_we[%0d] got=%0d exp=0", i, ctrl_writeEnable); end
      checks++; if (md_ready !== 1'b1) begin failures++; $display("FAIL rst_md_ready[%0d] got=%0d exp=1", i, md_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_wb_write();
    test_md_behind_wb();
    test_round_robin();
    test_r0_writes();
    test_pending_set_wins();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port of the 32x32 register file and shares it among three writers: pipeline writeback (WB), the multi-cycle mult/div unit (MD) and the debug/loader port (DBG).
- WB always has priority. MD and DBG take turns round-robin on cycles WB leaves free, and MD has a 1-entry holding buffer.
- Keeps a per-register pending scoreboard for in-flight MD destinations, used by hazard/stall logic.
- Drives the regfile's ctrl_writeEnable, ctrl_writeReg and data_writeReg from registered outputs.

Parameters:
- DATA_WIDTH, 32, write data width.
- ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH registers).

Ports:
- clock  in  1  system clock, rising edge.
- ctrl_reset  in  1  asynchronous, active-high reset.
- wb_we  in  1  writeback write request; cannot be stalled.
- wb_rd  in  ADDR_WIDTH  writeback destination.
- wb_data  in  DATA_WIDTH  writeback data.
- md_issue  in  1  MD operation started; marks md_issue_rd pending.
- md_issue_rd  in  ADDR_WIDTH  destination of the issued MD op.
- md_valid  in  1  MD result available.
- md_ready  out  1  MD result accepted this cycle when md_valid is high.
- md_rd  in  ADDR_WIDTH  MD result destination.
- md_data  in  DATA_WIDTH  MD result data.
- dbg_valid  in  1  debug write request.
- dbg_ready  out  1  debug write accepted this cycle when dbg_valid is high.
- dbg_rd  in  ADDR_WIDTH  debug destination.
- dbg_data  in  DATA_WIDTH  debug data.
- ctrl_writeEnable  out  1  to regfile write enable.
- ctrl_writeReg  out  ADDR_WIDTH  to regfile write address.
- data_writeReg  out  DATA_WIDTH  to regfile write data.
- wr_src  out  2  source of the current output write: 0 none, 1 WB, 2 MD, 3 DBG.
- pending  out  2**ADDR_WIDTH  scoreboard; bit i is set while an MD result for register i is outstanding.

Behaviour:
- Reset (asynchronous, immediate): ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, wr_src=0, pending=0, MD hold buffer emptied (its contents are dropped), rr_ptr=MD. A reset asserted mid-transfer discards all accepted-but-uncommitted writes.
- wb_active = wb_we & (wb_rd != 0). A WB write to r0 is ignored and does not occupy the port.
- Handshakes:
  - md_ready = !hold_full, independent of WB. This is combinational from state only.
  - The MD handshake (md_valid & md_ready) loads the hold buffer at the clock edge.
  - dbg_ready = !wb_active & (!hold_full | rr_ptr==DBG). DBG data is not buffered; it goes straight to the output register.
- Grant, evaluated each cycle:
  - WB if wb_active.
  - Else, with both hold_full and dbg_valid: the source rr_ptr points to.
  - Else whichever of the two is requesting.
  - After each MD or DBG grant, rr_ptr moves to the other source.
- A hold entry cannot be drained and refilled in the same cycle; md_ready stays low until the cycle after the drain.
- Latency:
  - The winning write is registered onto ctrl_* / wr_src at the clock edge, so WB and DBG appear 1 cycle after presentation.
  - An MD result appears no earlier than 2 cycles after its handshake.
  - On cycles with no grant, ctrl_writeEnable=0. ctrl_writeReg and data_writeReg hold their last values.
- r0 from MD or DBG: the handshake completes, the entry is consumed, and ctrl_writeEnable stays 0.
- Scoreboard:
  - md_issue with md_issue_rd != 0 sets pending[md_issue_rd] at the edge.
  - pending[md_rd] clears at the edge where the hold entry is granted onto the output.
  - Set and clear of the same index in the same cycle: set wins.
  - pending[0] is always 0.
  - Re-issuing an already-pending index leaves it set.
- WB starvation of MD/DBG is allowed by design; the pipeline guarantees idle WB slots.

Test Plan:
1. Reset, then wb_we=1, wb_rd=5, wb_data=0xDEADBEEF for 1 cycle -> next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF, wr_src=1; the following cycle ctrl_writeEnable=0.
2. md_issue rd=7, then md_valid rd=7 data=0x12 while wb_we is held high for 3 cycles -> md_ready=1 on the first cycle then 0; pending[7]=1 throughout. On the first WB-free cycle the MD write commits: ctrl_writeReg=7, data=0x12, wr_src=2, and pending[7] clears at that same edge.
3. Hold buffer full and dbg_valid=1 with WB idle for 4 cycles, and MD refilled with every opportunity -> wr_src sequence alternates 2,3,2,3 starting with MD; dbg_ready is high only on DBG-turn cycles.
4. dbg_valid rd=0 data=0xFF and wb_we rd=0 -> dbg_ready=1 and the handshake completes; ctrl_writeEnable stays 0, and WB to r0 does not block DBG.
5. md_issue rd=9 on the same cycle the hold entry for rd=9 is granted -> pending[9]=1 afterward. Separately, md_issue rd=0 -> pending stays 0.
6. Hold buffer full and pending[3]=1, then pulse ctrl_reset between clock edges -> all outputs 0 immediately and pending=0. After release the old MD entry is never written and md_ready=1.
